// File: rtl/sram_port_arbiter_if.sv
// Bundles the two split-transaction requester ports and the SRAM port of sram_port_arbiter.
// Latency: pure wiring, no state.
// Backpressure: addr_ok is the only stall; responses are never held back.
//
// Modports:
//   slave  - the arbiter: sees requests and sram_rdata, drives handshakes and the SRAM port.
//   master - the environment: the core's fetch/memory stages plus the SRAM itself.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  // load/store requester
  logic              data_req;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  // unified single-ported SRAM
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency single-ported SRAM between instruction fetch and load/store.
// Latency: addr_ok combinational with req; data_ok exactly one cycle after addr_ok; one grant per cycle.
// Backpressure: the loser of a conflict sees addr_ok=0 and holds req; responses are never stalled.
//
// Ports: clk, reset (synchronous, active-high), bus (sram_port_arbiter_if.slave) carrying both
// requester handshakes and the SRAM port.
// Build option: define ARB_RR_EN for round-robin conflict resolution; otherwise data always wins.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // strobes are 4 bits, so this must stay 32
) (
  input  logic                clk,
  input  logic                reset,
  sram_port_arbiter_if.slave  bus
);

  logic grant_inst;
  logic grant_data;
  logic grant_any;
  logic data_favoured;

  // Response tracking: one transaction outstanding at most, always retired next cycle.
  logic resp_vld_q, resp_vld_d;
  logic resp_owner_q, resp_owner_d;   // 0 = inst, 1 = data

`ifdef ARB_RR_EN
  // 1 = data favoured on the next conflict
  logic ptr_q, ptr_d;
  assign data_favoured = ptr_q;
`else
  assign data_favoured = 1'b1;
`endif

  // Grant selection. Requests seen while reset is high are never granted.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset) begin
      if (bus.inst_req && bus.data_req) begin
        grant_data = data_favoured;
        grant_inst = !data_favoured;
      end else begin
        grant_inst = bus.inst_req;
        grant_data = bus.data_req;
      end
    end
  end

  assign grant_any        = grant_inst | grant_data;
  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;

  // SRAM port is zeroed when idle so the bus never carries a stale address.
  always_comb begin
    bus.sram_en    = grant_any;
    bus.sram_we    = 4'h0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (grant_data) begin
      bus.sram_we    = bus.data_wstrb;
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
    end else if (grant_inst) begin
      bus.sram_addr  = bus.inst_addr;
    end
  end

  always_comb begin
    resp_vld_d   = grant_any;
    resp_owner_d = grant_any ? grant_data : resp_owner_q;
  end

`ifdef ARB_RR_EN
  // After any grant the non-winner becomes favoured.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_inst)      ptr_d = 1'b1;
    else if (grant_data) ptr_d = 1'b0;
  end
`endif

  // IDLE (resp_vld_q=0) / RESP (resp_vld_q=1) state.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_vld_q   <= 1'b0;
      resp_owner_q <= 1'b0;
`ifdef ARB_RR_EN
      ptr_q        <= 1'b1;
`endif
    end else begin
      resp_vld_q   <= resp_vld_d;
      resp_owner_q <= resp_owner_d;
`ifdef ARB_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  // A response caught by reset in its return cycle is dropped.
  assign bus.inst_data_ok = resp_vld_q && !resp_owner_q && !reset;
  assign bus.data_data_ok = resp_vld_q &&  resp_owner_q && !reset;

  assign bus.inst_rdata = bus.sram_rdata;
  assign bus.data_rdata = bus.sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle-latency SRAM behind it.
// Latency: inputs driven at the falling edge, outputs checked 1 ns later.
// Backpressure: none; the SRAM model answers every enabled cycle.
module tb_sram_port_arbiter;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed SRAM model: read returns the pre-write contents one cycle later.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sram_we[b]) mem[bus.sram_addr[9:2]][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
      end
      bus.sram_rdata <= mem[bus.sram_addr[9:2]];
    end
  end

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = 32'h0;
    bus.data_req   = 1'b0;
    bus.data_wstrb = 4'h0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_addr = addr; bus.data_wstrb = strb; bus.data_wdata = wd;
    #1;
    check("st_addr_ok", 64'(bus.data_addr_ok), 64'h1);
    check("st_we",      64'(bus.sram_we),      64'(strb));
    check("st_addr",    64'(bus.sram_addr),    64'(addr));
    check("st_wdata",   64'(bus.sram_wdata),   64'(wd));
    @(negedge clk);
    idle_inputs();
    #1;
    check("st_data_ok",   64'(bus.data_data_ok), 64'h1);
    check("st_no_inst_ok", 64'(bus.inst_data_ok), 64'h0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_addr = addr; bus.data_wstrb = 4'h0;
    #1;
    check("ld_addr_ok", 64'(bus.data_addr_ok), 64'h1);
    check("ld_we_zero", 64'(bus.sram_we),      64'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("ld_data_ok", 64'(bus.data_data_ok), 64'h1);
    check("ld_rdata",   64'(bus.data_rdata),   64'(exp));
  endtask

  initial begin
    logic [31:0] bb_exp [3];
    logic        exp_d, prev_d;
    n_total = 0;
    n_pass  = 0;
    bb_exp  = '{32'h02800421, 32'h11111111, 32'h22222222};

    // Reset, with a fetch request presented that must not be granted.
    reset = 1'b1;
    idle_inputs();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    check("rst_inst_addr_ok", 64'(bus.inst_addr_ok), 64'h0);
    check("rst_sram_en",      64'(bus.sram_en),      64'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("post_rst_inst_data_ok", 64'(bus.inst_data_ok), 64'h0);
    check("post_rst_data_data_ok", 64'(bus.data_data_ok), 64'h0);
    check("post_rst_sram_en",      64'(bus.sram_en),      64'h0);
    check("post_rst_sram_we",      64'(bus.sram_we),      64'h0);

    // Fill words 0..2 through the load/store port.
    do_store(32'h0, 4'hF, 32'h02800421);
    do_store(32'h4, 4'hF, 32'h11111111);
    do_store(32'h8, 4'hF, 32'h22222222);

    // Single fetch (0x1c000000 aliases word 0 in the model).
    @(negedge clk);
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000000;
    #1;
    check("f_inst_addr_ok", 64'(bus.inst_addr_ok), 64'h1);
    check("f_data_addr_ok", 64'(bus.data_addr_ok), 64'h0);
    check("f_sram_en",      64'(bus.sram_en),      64'h1);
    check("f_sram_we",      64'(bus.sram_we),      64'h0);
    check("f_sram_addr",    64'(bus.sram_addr),    64'h1c000000);
    @(negedge clk);
    idle_inputs();
    #1;
    check("f_inst_data_ok", 64'(bus.inst_data_ok), 64'h1);
    check("f_inst_rdata",   64'(bus.inst_rdata),   64'h02800421);
    check("f_data_data_ok", 64'(bus.data_data_ok), 64'h0);
    @(negedge clk);
    #1;
    check("f_done_inst_ok", 64'(bus.inst_data_ok), 64'h0);
    check("f_idle_sram_en", 64'(bus.sram_en),      64'h0);
    check("f_idle_addr",    64'(bus.sram_addr),    64'h0);

    // Full-word store and read-back.
    do_store(32'h100, 4'hF, 32'hDEADBEEF);
    do_load(32'h100, 32'hDEADBEEF);

    // Back-to-back fetches: three consecutive responses with no gap.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin
        bus.inst_req = 1'b1; bus.inst_addr = 32'(4 * k);
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 3) begin
        check("bb_addr_ok", 64'(bus.inst_addr_ok), 64'h1);
        check("bb_addr",    64'(bus.sram_addr),    64'(4 * k));
      end
      if (k > 0) begin
        check("bb_data_ok", 64'(bus.inst_data_ok), 64'h1);
        check("bb_rdata",   64'(bus.inst_rdata),   64'(bb_exp[k-1]));
      end else begin
        check("bb_first_no_ok", 64'(bus.inst_data_ok), 64'h0);
      end
    end

    // Conflict from a fresh reset so the round-robin pointer starts on data.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prev_d = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        bus.inst_req = 1'b1; bus.inst_addr = 32'h10;
        bus.data_req = 1'b1; bus.data_addr = 32'h20; bus.data_wstrb = 4'h0;
      end else begin
        idle_inputs();
      end
      #1;
      exp_d = (k < 4) && (!RR || (k % 2 == 0));
      check("cf_data_addr_ok", 64'(bus.data_addr_ok), 64'(exp_d));
      check("cf_inst_addr_ok", 64'(bus.inst_addr_ok), 64'((k < 4) && !exp_d));
      if (k > 0) begin
        check("cf_data_data_ok", 64'(bus.data_data_ok), 64'(prev_d));
        check("cf_inst_data_ok", 64'(bus.inst_data_ok), 64'(!prev_d));
      end
      prev_d = exp_d;
    end

    // Reset in the response cycle of a granted fetch.
    @(negedge clk);
    bus.inst_req = 1'b1; bus.inst_addr = 32'h4;
    #1;
    check("rm_addr_ok", 64'(bus.inst_addr_ok), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rm_dropped_ok", 64'(bus.inst_data_ok), 64'h0);
    check("rm_rst_addr_ok", 64'(bus.inst_addr_ok), 64'h0);
    check("rm_rst_sram_en", 64'(bus.sram_en),      64'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rm_inst_data_ok", 64'(bus.inst_data_ok), 64'h0);
    check("rm_data_data_ok", 64'(bus.data_data_ok), 64'h0);
    check("rm_sram_en",      64'(bus.sram_en),      64'h0);
    check("rm_sram_we",      64'(bus.sram_we),      64'h0);
    check("rm_sram_addr",    64'(bus.sram_addr),    64'h0);

    // Byte store touches only byte 1 of word 0x200.
    do_store(32'h200, 4'hF, 32'hAABBCCDD);
    do_store(32'h203, 4'h2, 32'h00005500);
    do_load(32'h200, 32'hAABB55DD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-ported, 1-cycle-latency SRAM between the CPU's instruction-fetch requester and its load/store requester. Each requester uses a split-transaction handshake: `*_req`, then `*_addr_ok`, then `*_data_ok`. The block sits between the core's fetch/memory stages and the unified memory. It grants at most one access per cycle and returns each response to the requester that issued it, one cycle after the grant. It pipelines back-to-back grants with no bubble.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; must be 32, because strobes are 4 bits.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `inst_req` in 1: fetch request valid.
- `inst_addr` in ADDR_W: fetch address.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch response valid this cycle.
- `inst_rdata` out DATA_W: fetch read data.
- `data_req` in 1: load/store request valid.
- `data_wstrb` in 4: byte write strobes; 0 means read.
- `data_addr` in ADDR_W: load/store address.
- `data_wdata` in DATA_W: store data.
- `data_addr_ok` out 1: load/store request accepted this cycle.
- `data_data_ok` out 1: load/store response valid this cycle (reads and writes).
- `data_rdata` out DATA_W: load read data.
- `sram_en` out 1: SRAM access enable.
- `sram_we` out 4: SRAM byte write enables.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_wdata` out DATA_W: SRAM write data.
- `sram_rdata` in DATA_W: SRAM read data, valid in the cycle after `sram_en` was sampled.

## Operation
Grant logic (combinational, each cycle):
- If both requesters assert `req`, select a winner by the priority policy (see Configuration).
- If only one asserts `req`, it wins.
- The winner's `addr_ok` is 1; the loser's `addr_ok` is 0.

Driving the SRAM:
- `sram_en` = any grant.
- `sram_addr` and `sram_wdata` are muxed from the winner.
- `sram_we` = `data_wstrb` when data wins; `sram_we` = 0 when fetch wins.
- With no grant: `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0.

Response tracking:
- Registers `resp_vld` and `resp_owner` (0 = inst, 1 = data) capture each grant at the clock edge.
- In the next cycle, `resp_owner`'s `data_ok` = `resp_vld`.
- Both `inst_rdata` and `data_rdata` are driven from `sram_rdata` in every cycle; the value is meaningful only when that requester's `data_ok` is 1.

Requester rules:
- Requesters hold `req`, `addr`, `wstrb` and `wdata` stable until `addr_ok` is returned.
- Requesters always accept `data_ok`; the block applies no response backpressure.
- A requester may issue its next `req` in the same cycle as its `data_ok`.
- At most one outstanding transaction exists in total, and it is always retired in the following cycle, so no FIFO is required.

States are implicit: IDLE (`resp_vld`=0) and RESP (`resp_vld`=1). Transitions:
- IDLE to RESP on any grant.
- RESP to RESP on a grant in the same cycle as the response (pipelined).
- RESP to IDLE when there is no grant.

## Timing
- Reset values: `resp_vld`=0, `resp_owner`=0, priority pointer=1 (data favoured first). Every `*_addr_ok`, `*_data_ok` and `sram_en` output reads 0 in the cycle after reset is sampled. `sram_we`=0.
- `addr_ok` is combinational from `req` in the same cycle.
- `data_ok` arrives exactly 1 cycle after `addr_ok`.
- Throughput: 1 grant per cycle.
- Simultaneous requests: the loser waits at least 1 cycle and keeps `req` high.
- Reset mid-transaction: any pending response is dropped, and `data_ok` is not asserted for it.
- A request presented while `reset`=1 is not granted: every `addr_ok` is 0 while `reset`=1.

## Configuration
Macro `ARB_RR_EN`.
- When defined: round-robin priority.
  - A 1-bit pointer names the favoured requester on a conflict.
  - After any grant, the pointer moves to the non-winner.
  - Under continuous dual requests, grants alternate data, inst, data, …
- When not defined: fixed priority, with data always winning a conflict.
  - Fetch can starve while `data_req` stays high.
  - The pointer register is not instantiated.

## Test plan
- Single fetch: `inst_req`=1 at `0x1c000000`, with `sram_rdata`=`0x02800421` in the next cycle. Required: `inst_addr_ok`=1 in cycle 0; `inst_data_ok`=1 and `inst_rdata`=`0x02800421` in cycle 1; `data_data_ok`=0 throughout.
- Store: `data_req`=1, `wstrb`=`0xF`, addr=`0x100`, wdata=`0xDEADBEEF`. Required: `sram_we`=`0xF` and `sram_addr`=`0x100` in the grant cycle; `data_data_ok`=1 in the next cycle.
- Conflict: both `req` held high for 4 cycles. Required: fixed priority gives grants D,D,D,D with `inst_addr_ok` never 1; with `ARB_RR_EN`, grants are D,I,D,I and each `data_ok` goes to the matching owner 1 cycle later.
- Back-to-back: fetch at `0x0`, `0x4`, `0x8` on consecutive cycles. Required: 3 consecutive `inst_data_ok` pulses, with no idle cycle between them.
- Reset mid-operation: grant a fetch, then assert `reset` in the next cycle. Required: no `inst_data_ok` for that fetch; all outputs 0 after reset.
- Byte store: `wstrb`=`0x2`, addr=`0x203`. Required: `sram_we`=`0x2`, and the read-back at `0x200` changes only byte 1.
